lsu_ram: RTL and testbench
==========================

# lsu_ram

Parametrised synchronous data RAM with a RISC-V load/store front end. It decodes funct3 and byte address into byte-lane writes and sign- or zero-extended reads, flags misaligned, illegal and out-of-range accesses, and returns one response per request through a valid/ready handshake. Read latency is configurable. It sits between the core's memory stage and data storage, replacing the combinational byte-select RAM.

## Interface
- DEPTH, 1024: number of 32-bit words; power of two, ≥ 4.
- READ_LATENCY, 1: cycles from request accept to earliest `rsp_valid`; legal values 1 or 2.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32 load/store funct3.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; lane 0 holds the low byte/half.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  access rejected.

## Operation
- FSM states: IDLE, WAIT, RESP. `req_ready` = (state == IDLE) && !rst.
- Accept: `req_valid && req_ready` at a rising edge. Request fields are sampled only at that edge.
- Word index = `req_addr[31:2]`. Offset = `req_addr[1:0]`.
- Out of range: word index ≥ DEPTH gives err.
- Legal load funct3 values:
  - 000 LB, 100 LBU: any offset.
  - 001 LH, 101 LHU: offset[0] = 0.
  - 010 LW: offset = 0.
  - 011, 110, 111: illegal, err.
- Legal store funct3 values: 000 SB, 001 SH, 010 SW, with the same alignment rules. All others are illegal, err.
- Store lanes:
  - SB: 4'b0001 << offset; byte = `wdata[7:0]` placed in that lane.
  - SH: 4'b0011 << offset; half = `wdata[15:0]`.
  - SW: 4'b1111.
  - Unselected bytes are unchanged.
- Load: select the byte or half at the offset. LB/LH sign-extend; LBU/LHU zero-extend.
- Error: no memory write; `rsp_rdata` = 0, `rsp_err` = 1.
- The memory write commits at the accept edge. The read samples the array at the accept edge.
- Store response: `rsp_rdata` = 0, `rsp_err` per the checks above.
- Transitions:
  - IDLE → RESP on accept when READ_LATENCY = 1.
  - IDLE → WAIT on accept when READ_LATENCY = 2.
  - WAIT → RESP unconditionally.
  - RESP → IDLE on `rsp_valid && rsp_ready`.
- Memory contents are not reset or cleared and are undefined at power-up.

## Timing
- Reset values: state IDLE, `rsp_valid` 0, `rsp_rdata` 0, `rsp_err` 0, `req_ready` 0 while `rst` = 1 and 1 on the first cycle after.
- Accept at edge N:
  - `rsp_valid` = 1 from edge N + READ_LATENCY onward.
  - `rsp_rdata`/`rsp_err` are registered, valid together with `rsp_valid`, and stable while `rsp_valid && !rsp_ready`.
- Response handshake completes at edge M. `rsp_valid` = 0 and `req_ready` = 1 after edge M. The next accept is possible at edge M+1.
- Peak throughput is one transaction per READ_LATENCY + 1 cycles.
- `rsp_ready` held high before a response exists has no effect.
- Load immediately following a store to the same word returns the updated bytes, because the store committed at its own earlier accept edge.
- `rst` during WAIT or RESP: the pending response is dropped and state returns to IDLE. A store accepted before reset stays committed.
- `rst` and `req_valid` in the same cycle: the request is not accepted and memory is not written.

## Test plan
- Reset, then SW addr 0x0, data 0x8899AABB, then LW 0x0 → store response `rsp_err` 0; load returns 0x8899AABB after READ_LATENCY cycles.
- After 0x8899AABB is at word 0:
  - LB 0x3 → 0xFFFFFF88.
  - LBU 0x3 → 0x00000088.
  - LH 0x2 → 0xFFFF8899.
  - LHU 0x0 → 0x0000AABB.
- SB 0x1 data 0x12, then SH 0x2 data 0x3456 → LW 0x0 returns 0x345612BB. A store with `req_wdata` upper bits set to ones leaves the other lanes untouched.
- Error cases, each giving `rsp_err` 1 and `rsp_rdata` 0:
  - LW 0x2.
  - SH 0x1: memory unchanged.
  - Load funct3 011.
  - SW at byte address 4·DEPTH: memory unchanged.
- Backpressure: hold `rsp_ready` 0 for 5 cycles → `rsp_valid`/`rsp_rdata` stable and `req_ready` 0 throughout; the new request is accepted only on the cycle after `rsp_ready` rises.
- Reset mid-transaction: assert `rst` in WAIT (READ_LATENCY = 2) or RESP → `rsp_valid` 0 the next cycle and no stale response afterward. A store accepted earlier is still readable after reset.

Source files
------------

// File: rtl/lsu_ram.sv
// rtl/lsu_ram.sv - RV32 load/store front end over a synchronous word RAM
// Stores commit and loads sample the array at the accept edge; the response is held in registers.
module lsu_ram #(
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] mem_q [DEPTH];

  logic          accept;
  logic          in_range;
  logic          legal;
  logic          aligned;
  logic          err;
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic [3:0]    be;
  logic [31:0]   wdata_lane;
  logic [31:0]   rword;
  logic [31:0]   shifted;
  logic [31:0]   load_data;

  assign idx      = req_addr[AW+1:2];
  assign off      = req_addr[1:0];
  assign in_range = (req_addr[31:AW+2] == '0);

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Size comes from funct3[1:0]; stores additionally forbid funct3[2].
  always_comb begin
    aligned    = 1'b0;
    be         = 4'b0000;
    wdata_lane = 32'h0;
    legal      = (req_funct3[1:0] != 2'b11) &&
                 (req_we ? !req_funct3[2] : (req_funct3 != 3'b110));
    case (req_funct3[1:0])
      2'b00: begin
        aligned    = 1'b1;
        be         = 4'b0001 << off;
        wdata_lane = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        aligned    = !off[0];
        be         = 4'b0011 << off;
        wdata_lane = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        aligned    = (off == 2'b00);
        be         = 4'b1111;
        wdata_lane = req_wdata;
      end
      default: begin
        aligned = 1'b0;
      end
    endcase
    err = !legal || !aligned || !in_range;
  end

  assign rword   = mem_q[idx];
  assign shifted = rword >> {off, 3'b000};

  always_comb begin
    case (req_funct3)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_data = {24'h0, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_data = {16'h0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept && req_we && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_q[idx][8*b +: 8] <= wdata_lane[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = (READ_LATENCY == 2) ? WAIT : RESP;
          rsp_err_d   = err;
          rsp_rdata_d = (err || req_we) ? 32'h0 : load_data;
        end
      end
      WAIT: state_d = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_lsu_ram.sv
// tb/tb_lsu_ram.sv - randomized and directed checks of lsu_ram against a byte-array model
module tb_lsu_ram;
  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [4*DEPTH];

  lsu_ram #(.DEPTH(DEPTH), .READ_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: access size 1<<funct3[1:0], natural alignment, little-endian bytes.
  task automatic ref_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int unsigned size;
    logic illegal;
    logic [31:0] val;
    size    = 1 << f3[1:0];
    illegal = (f3[1:0] == 2'b11) || (we ? f3[2] : (f3 == 3'b110));
    er      = illegal || ((addr % size) != 0) || ((addr >> 2) >= DEPTH);
    rd      = 32'h0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < int'(size); i++) ref_mem[addr + i] = wd[8*i +: 8];
      end else begin
        val = 32'h0;
        for (int i = 0; i < int'(size); i++) val = val | (32'(ref_mem[addr + i]) << (8*i));
        if (!f3[2] && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8*size));
        rd = val;
      end
    end
  endtask

  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input string tag, output logic [31:0] obs);
    logic [31:0] exp_rd;
    logic exp_er;
    int n;
    bit got;
    obs = 32'hx;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: req_ready=%b required 1", tag, req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    ref_access(we, f3, addr, wd, exp_rd, exp_er);
    #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
    got = 0; n = 0;
    for (int k = 1; k <= LAT + 3; k++) begin
      @(negedge clk);
      n = k;
      if (rsp_valid === 1'b1) begin
        got = 1;
        break;
      end
    end
    obs = rsp_rdata;
    checks++;
    if (!got || n != LAT) begin
      errors++;
      $display("FAIL %s latency: got %0d (seen=%0d) required %0d", tag, n, got, LAT);
    end
    checks++;
    if (rsp_rdata !== exp_rd) begin
      errors++;
      $display("FAIL %s rdata: got %h required %h", tag, rsp_rdata, exp_rd);
    end
    checks++;
    if (rsp_err !== exp_er) begin
      errors++;
      $display("FAIL %s err: got %b required %b", tag, rsp_err, exp_er);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release: rsp_valid=%b req_ready=%b required 0/1", tag, rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_we = 1'b0; req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: ready=%b valid=%b rdata=%h err=%b required 0/0/0/0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] o;
    do_txn(1'b1, 3'b010, 32'h0, 32'h8899AABB, "sw0", o);
    do_txn(1'b0, 3'b010, 32'h0, 32'h0, "lw0", o);
    checks++; if (o !== 32'h8899AABB) begin errors++; $display("FAIL lw0_const: got %h required 8899aabb", o); end
    do_txn(1'b0, 3'b000, 32'h3, 32'h0, "lb3", o);
    checks++; if (o !== 32'hFFFFFF88) begin errors++; $display("FAIL lb3_const: got %h required ffffff88", o); end
    do_txn(1'b0, 3'b100, 32'h3, 32'h0, "lbu3", o);
    checks++; if (o !== 32'h00000088) begin errors++; $display("FAIL lbu3_const: got %h required 00000088", o); end
    do_txn(1'b0, 3'b001, 32'h2, 32'h0, "lh2", o);
    checks++; if (o !== 32'hFFFF8899) begin errors++; $display("FAIL lh2_const: got %h required ffff8899", o); end
    do_txn(1'b0, 3'b101, 32'h0, 32'h0, "lhu0", o);
    checks++; if (o !== 32'h0000AABB) begin errors++; $display("FAIL lhu0_const: got %h required 0000aabb", o); end
    do_txn(1'b1, 3'b000, 32'h1, 32'hFFFFFF12, "sb1", o);
    do_txn(1'b1, 3'b001, 32'h2, 32'hFFFF3456, "sh2", o);
    do_txn(1'b0, 3'b010, 32'h0, 32'h0, "lw_lanes", o);
    checks++; if (o !== 32'h345612BB) begin errors++; $display("FAIL lanes_const: got %h required 345612bb", o); end
    do_txn(1'b0, 3'b010, 32'h2, 32'h0, "lw_misalign", o);
    do_txn(1'b1, 3'b001, 32'h1, 32'hFFFFFFFF, "sh_misalign", o);
    do_txn(1'b0, 3'b011, 32'h0, 32'h0, "load_f3_011", o);
    do_txn(1'b1, 3'b010, 32'(4*DEPTH), 32'hDEADBEEF, "sw_oor", o);
    do_txn(1'b0, 3'b010, 32'h0, 32'h0, "lw_after_err", o);
    checks++; if (o !== 32'h345612BB) begin errors++; $display("FAIL err_nowrite: got %h required 345612bb", o); end
  endtask

  task automatic fill_memory();
    logic [31:0] o;
    for (int w = 1; w < DEPTH; w++) do_txn(1'b1, 3'b010, 32'(w*4), $urandom, "fill", o);
  endtask

  task automatic test_random();
    logic [31:0] o, a;
    for (int t = 0; t < 300; t++) begin
      a = 32'($urandom_range(0, DEPTH + 3)) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = a | 32'h8000_0000;
      do_txn(1'($urandom), 3'($urandom), a, $urandom, "random", o);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp1, exp2, snap;
    logic e1, e2;
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8; rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    ref_access(1'b0, 3'b010, 32'h8, 32'h0, exp1, e1);
    #1;
    req_addr = 32'hC;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    snap = rsp_rdata;
    checks++;
    if (rsp_valid !== 1'b1 || snap !== exp1) begin
      errors++;
      $display("FAIL bp_first: valid=%b rdata=%h required 1/%h", rsp_valid, snap, exp1);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== snap || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b rdata=%h ready=%b required 1/%h/0",
                 c, rsp_valid, rsp_rdata, req_ready, snap);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid=%b ready=%b required 0/1", rsp_valid, req_ready);
    end
    @(posedge clk);
    ref_access(1'b0, 3'b010, 32'hC, 32'h0, exp2, e2);
    #1;
    req_valid = 1'b0;
    repeat (LAT) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== exp2 || rsp_err !== e2) begin
      errors++;
      $display("FAIL bp_second: valid=%b rdata=%h err=%b required 1/%h/%b",
               rsp_valid, rsp_rdata, rsp_err, exp2, e2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] o;
    bit stale;
    int n;
    do_txn(1'b1, 3'b010, 32'h10, $urandom, "rm_store", o);
    for (int phase = 0; phase < 2; phase++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; rsp_ready = 1'b0;
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      if (phase == 1) begin
        n = 0;
        while (rsp_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid%0d: rsp_valid=%b required 0", phase, rsp_valid);
      end
      rst = 1'b0;
      rsp_ready = 1'b1;
      stale = 0;
      repeat (6) begin
        @(negedge clk);
        if (rsp_valid !== 1'b0) stale = 1;
      end
      checks++;
      if (stale) begin
        errors++;
        $display("FAIL rst_stale%0d: rsp_valid seen 1 required 0", phase);
      end
    end
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h14;
    req_wdata = ~{ref_mem[23], ref_mem[22], ref_mem[21], ref_mem[20]};
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    do_txn(1'b0, 3'b010, 32'h14, 32'h0, "rst_with_req", o);
    do_txn(1'b0, 3'b010, 32'h10, 32'h0, "store_survives", o);
  endtask

  initial begin
    test_reset();
    test_directed();
    fill_memory();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
